// File: rtl/irrigacao_controlador.sv
// Valve sequencer for the irrigation system: debounces the watering requests, opens at most one
// valve at a time, and enforces minimum run, maximum run and pause times in ticks of the time base.
module irrigacao_controlador #(
  parameter int DEB_TICKS   = 4,
  parameter int MIN_ON      = 10,
  parameter int MAX_ON      = 60,
  parameter int PAUSA_TICKS = 8,
  parameter int CW          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       req_asp,
  input  logic       req_got,
  input  logic       nivel_h,
  input  logic       nivel_m,
  input  logic       nivel_l,
  output logic       valv_asp,
  output logic       valv_got,
  output logic       erro_nivel,
  output logic       fim_tempo,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    CONFIRMA    = 3'd1,
    ASPERSAO    = 3'd2,
    GOTEJAMENTO = 3'd3,
    PAUSA       = 3'd4,
    ERRO        = 3'd5
  } estadoT;

  localparam logic [CW-1:0] DEB_C   = CW'(DEB_TICKS);
  localparam logic [CW-1:0] MIN_C   = CW'(MIN_ON);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_ON);
  localparam logic [CW-1:0] PAUSA_C = CW'(PAUSA_TICKS);

  estadoT        state, stateNext;
  logic [CW-1:0] cnt, cntNext, cntInc;
  logic          selGot, selGotNext;
  logic          fimNext;
  logic          lvlErr;
  logic          reqSel;

  // A higher sensor wet while a lower one is dry can only be a sensor fault.
  assign lvlErr = (nivel_h & ~nivel_m) | (nivel_h & ~nivel_l) | (nivel_m & ~nivel_l);
  assign reqSel = selGot ? req_got : req_asp;
  assign cntInc = cnt + 1'b1;

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      selGot    <= 1'b0;
      fim_tempo <= 1'b0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      selGot    <= selGotNext;
      fim_tempo <= fimNext;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    selGotNext = selGot;
    fimNext    = 1'b0;

    if (lvlErr) begin
      stateNext = ERRO;
      cntNext   = '0;
    end else begin
      case (state)
        IDLE: begin
          cntNext = '0;
          if (nivel_l && (req_asp || req_got)) begin
            stateNext  = CONFIRMA;
            selGotNext = req_got;
          end
        end

        CONFIRMA: begin
          if (!reqSel || !nivel_l) begin
            stateNext = IDLE;
            cntNext   = '0;
          end else if (tick) begin
            if (cntInc == DEB_C) begin
              stateNext = selGot ? GOTEJAMENTO : ASPERSAO;
              cntNext   = '0;
            end else begin
              cntNext = cntInc;
            end
          end
        end

        ASPERSAO, GOTEJAMENTO: begin
          // Exit priority: dry tank, then timeout, then request release after the minimum run.
          if (!nivel_l) begin
            stateNext = PAUSA;
            cntNext   = '0;
          end else if (tick && (cntInc == MAX_C)) begin
            stateNext = PAUSA;
            cntNext   = '0;
            fimNext   = 1'b1;
          end else if (!reqSel && (cnt >= MIN_C)) begin
            stateNext = PAUSA;
            cntNext   = '0;
          end else if (tick && (cnt != MAX_C)) begin
            cntNext = cntInc;
          end
        end

        PAUSA: begin
          if (tick) begin
            if (cntInc == PAUSA_C) begin
              stateNext = IDLE;
              cntNext   = '0;
            end else begin
              cntNext = cntInc;
            end
          end
        end

        ERRO: begin
          cntNext = '0;
          if (tick) begin
            stateNext = PAUSA;
          end
        end

        default: begin
          stateNext  = IDLE;
          cntNext    = '0;
          selGotNext = 1'b0;
        end
      endcase
    end
  end

  assign valv_asp   = (state == ASPERSAO);
  assign valv_got   = (state == GOTEJAMENTO);
  assign erro_nivel = (state == ERRO);
  assign estado     = state;

endmodule
